synth_cfg_tx: RTL

- CPU-clock-domain initiator for the synth configuration 4-phase req/ack handshake.
- Owns MMIO shadow registers for carrier FCWs, mod FCW, mod shift and note enables.
- On a commit write, snapshots the shadows into held output registers and drives cpu_req until the synchronized cpu_ack completes the cycle.
- Outputs drive the cpu_* inputs of the CPU-to-synth CDC; cpu_ack comes from its cpu-side synchronizer.

---
 rtl/synth_cfg_tx_if.sv | 32 +++
 rtl/synth_cfg_tx.sv | 98 +++++++++
 2 files changed

// File: rtl/synth_cfg_tx_if.sv
// MMIO write port, config handshake and status bundle for the synth
// configuration initiator.
interface synth_cfg_tx_if #(
  parameter int N_VOICES = 1
);
  logic                    wr_en;
  logic [7:0]              wr_addr;
  logic [31:0]             wr_data;
  logic                    cpu_ack;
  logic                    cpu_req;
  logic [N_VOICES*24-1:0]  cpu_carrier_fcws;
  logic [23:0]             cpu_mod_fcw;
  logic [4:0]              cpu_mod_shift;
  logic [N_VOICES-1:0]     cpu_note_en;
  logic                    busy;
  logic                    pending;
  logic                    xfer_done;
  logic [15:0]             xfer_count;

  // The initiator receives MMIO writes and the synchronized ack.
  modport master (
    input  wr_en, wr_addr, wr_data, cpu_ack,
    output cpu_req, cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en,
           busy, pending, xfer_done, xfer_count
  );

  modport slave (
    output wr_en, wr_addr, wr_data, cpu_ack,
    input  cpu_req, cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en,
           busy, pending, xfer_done, xfer_count
  );
endinterface

// File: rtl/synth_cfg_tx.sv
// CPU-side initiator of the synth config 4-phase req/ack handshake: MMIO
// shadow registers, commit snapshot into held outputs, coalescing re-launch.
module synth_cfg_tx #(
  parameter int N_VOICES = 1
) (
  input logic           clk,
  input logic           rst_n,
  synth_cfg_tx_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                 state;
  logic [N_VOICES*24-1:0] carrier_sh;
  logic [23:0]            mod_fcw_sh;
  logic [4:0]             mod_shift_sh;
  logic [N_VOICES-1:0]    note_en_sh;
  logic                   commit;
  logic                   launch;

  assign commit   = bus.wr_en && (bus.wr_addr == 8'h03);
  assign launch   = commit || bus.pending;
  assign bus.busy = (state != IDLE);

  // NOTE: shadows are ordinary flops, not a RAM, so they take the async reset
  // and a commit straight after reset transfers a defined all-zero config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_sh   <= '0;
      mod_fcw_sh   <= '0;
      mod_shift_sh <= '0;
      note_en_sh   <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        8'h00:   mod_fcw_sh   <= bus.wr_data[23:0];
        8'h01:   mod_shift_sh <= bus.wr_data[4:0];
        8'h02:   note_en_sh   <= bus.wr_data[N_VOICES-1:0];
        default: ;
      endcase
      for (int i = 0; i < N_VOICES; i++) begin
        if (bus.wr_addr == 8'(16 + i)) carrier_sh[24*i +: 24] <= bus.wr_data[23:0];
      end
    end
  end

  // NOTE: every state/output register here uses <= so all of them see the
  // pre-edge values of state, pending and the shadows within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      bus.cpu_req          <= 1'b0;
      bus.cpu_carrier_fcws <= '0;
      bus.cpu_mod_fcw      <= '0;
      bus.cpu_mod_shift    <= '0;
      bus.cpu_note_en      <= '0;
      bus.pending          <= 1'b0;
      bus.xfer_done        <= 1'b0;
      bus.xfer_count       <= '0;
    end else begin
      bus.xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            if (!bus.cpu_ack) begin
              state                <= REQ;
              bus.cpu_req          <= 1'b1;
              bus.pending          <= 1'b0;
              bus.cpu_carrier_fcws <= carrier_sh;
              bus.cpu_mod_fcw      <= mod_fcw_sh;
              bus.cpu_mod_shift    <= mod_shift_sh;
              bus.cpu_note_en      <= note_en_sh;
            end else begin
              // Ack still high from a previous cycle: hold the launch.
              bus.pending <= 1'b1;
            end
          end
        end
        REQ: begin
          if (commit) bus.pending <= 1'b1;
          if (bus.cpu_ack) begin
            state       <= REL;
            bus.cpu_req <= 1'b0;
          end
        end
        REL: begin
          if (commit) bus.pending <= 1'b1;
          if (!bus.cpu_ack) begin
            state          <= IDLE;
            bus.xfer_done  <= 1'b1;
            bus.xfer_count <= bus.xfer_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
